// File: rtl/btb_pkg.sv
// Shared types, counter limits and parameter legality checks for the
// set-associative branch target buffer.
package btb_pkg;

  localparam int BTB_DEF_PC_W  = 32;
  localparam int BTB_DEF_IDX_W = 9;
  localparam int BTB_DEF_CTR_W = 2;
  localparam int BTB_DEF_TAG_W = BTB_DEF_PC_W - BTB_DEF_IDX_W - 2;

  // Entry layout of the default configuration; the top sizes its own
  // per-field storage from its parameters with the same fields.
  typedef struct packed {
    logic [BTB_DEF_TAG_W-1:0] tag;
    logic [BTB_DEF_PC_W-1:0]  target;
    logic [BTB_DEF_CTR_W-1:0] counter;
    logic                     valid;
  } btb_entry_t;

  localparam int unsigned BTB_CTR_MIN = 0;

  function automatic longint unsigned btb_ctr_max(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic bit btb_params_legal(int entries, int ways, int pc_w, int ctr_w);
    bit ok;
    int sets;
    ok = 1'b1;
    if (ways != 1 && ways != 2 && ways != 4) ok = 1'b0;
    if (entries <= 0 || (entries & (entries - 1)) != 0) ok = 1'b0;
    if (ways > 0 && (entries % ways) != 0) ok = 1'b0;
    sets = (ways > 0) ? entries / ways : 0;
    if (sets < 2) ok = 1'b0;
    if (ctr_w < 1 || ctr_w > 32) ok = 1'b0;
    if (sets >= 2 && pc_w <= $clog2(sets) + 2) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Saturating up/down direction predictor counter used on the BTB write path.
module btb_sat_counter
  import btb_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             taken,
  input  logic [CTR_W-1:0] current,
  output logic [CTR_W-1:0] next_ctr
);

  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(btb_ctr_max(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MIN = CTR_W'(BTB_CTR_MIN);

  always_comb begin
    next_ctr = current;
    if (taken) begin
      if (current != CTR_MAX) next_ctr = current + CTR_W'(1);
    end else begin
      if (current != CTR_MIN) next_ctr = current - CTR_W'(1);
    end
  end

endmodule

// File: rtl/assoc_branch_target_buffer.sv
// Set-associative branch target buffer: zero-latency lookup, true-LRU
// replacement, saturating direction counters and a lookup hit counter.
module assoc_branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRIES         = 1024,
  parameter int WAYS            = 2,
  parameter int PC_W            = 32,
  parameter int CTR_W           = 2,
  parameter bit ALLOC_NOT_TAKEN = 1'b1
) (
  input  logic            btb_clk,
  input  logic            btb_reset,
  input  logic [PC_W-1:0] btb_pc,
  input  logic            btb_lookup_en,
  input  logic            btb_write,
  input  logic [PC_W-1:0] btb_new_pc,
  input  logic [PC_W-1:0] btb_data,
  input  logic            btb_branch_taken,
  input  logic            btb_flush,
  output logic            btb_hit,
  output logic            btb_valid_prediction,
  output logic [PC_W-1:0] btb_target,
  output logic [31:0]     btb_hit_count
);

  localparam int SETS  = ENTRIES / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(btb_ctr_max(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MIN = CTR_W'(BTB_CTR_MIN);

  if (!btb_params_legal(ENTRIES, WAYS, PC_W, CTR_W)) begin : g_illegal_params
    $error("assoc_branch_target_buffer: illegal ENTRIES/WAYS/PC_W/CTR_W combination");
  end

  typedef logic [WAY_W-1:0] way_t;
  typedef logic [WAY_W-1:0] age_t;
  typedef age_t [WAYS-1:0]  ages_t;

  // Per-set LRU is a permutation of ages: 0 is most recent, WAYS-1 is the victim.
  function automatic ages_t ages_init();
    ages_t r;
    for (int i = 0; i < WAYS; i++) r[i] = age_t'(i);
    return r;
  endfunction

  localparam ages_t AGES_INIT = ages_init();

  function automatic ages_t lru_touch(ages_t a, way_t way);
    ages_t r;
    r = a;
    for (int i = 0; i < WAYS; i++) begin
      if (a[i] < a[way]) r[i] = a[i] + age_t'(1);
    end
    r[way] = '0;
    return r;
  endfunction

  function automatic way_t lru_oldest(ages_t a);
    way_t v;
    v = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (a[i] == age_t'(WAYS - 1)) v = way_t'(i);
    end
    return v;
  endfunction

  logic [WAYS-1:0]  valid_q [SETS];
  ages_t            lru_q   [SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [PC_W-1:0]  tgt_q   [WAYS][SETS];
  logic [CTR_W-1:0] ctr_q   [WAYS][SETS];
  logic [31:0]      hit_count_q, hit_count_d;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit, lookup_touch;
  logic             wr_alloc, wr_en, wr_tgt_en;
  way_t             rd_way, wr_way, wr_victim, wr_sel;
  ages_t            lru_rd_d, lru_wr_base, lru_wr_d;
  logic [CTR_W-1:0] rd_ctr, wr_cur_ctr, ctr_upd, wr_ctr;
  logic             unused_pc_low_bits;

  assign rd_idx = btb_pc[IDX_W+1:2];
  assign rd_tag = btb_pc[PC_W-1:IDX_W+2];
  assign wr_idx = btb_new_pc[IDX_W+1:2];
  assign wr_tag = btb_new_pc[PC_W-1:IDX_W+2];
  assign unused_pc_low_bits = ^{btb_pc[1:0], btb_new_pc[1:0]};

  always_comb begin
    rd_hit = 1'b0;
    rd_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[rd_idx][w] && tag_q[w][rd_idx] == rd_tag) begin
        rd_hit = 1'b1;
        rd_way = way_t'(w);
      end
    end
    rd_ctr               = ctr_q[rd_way][rd_idx];
    btb_hit              = rd_hit;
    btb_valid_prediction = rd_hit & rd_ctr[CTR_W-1];
    btb_target           = btb_valid_prediction ? tgt_q[rd_way][rd_idx] : btb_pc + PC_W'(4);
    lookup_touch         = rd_hit & btb_lookup_en;
    lru_rd_d             = lru_touch(lru_q[rd_idx], rd_way);
  end

  // A same-set lookup hit is applied to the LRU order before the write, so the
  // write's way ends up most recent and the looked-up way is never the victim.
  always_comb begin
    wr_hit = 1'b0;
    wr_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[wr_idx][w] && tag_q[w][wr_idx] == wr_tag) begin
        wr_hit = 1'b1;
        wr_way = way_t'(w);
      end
    end
    lru_wr_base = (lookup_touch && rd_idx == wr_idx) ? lru_rd_d : lru_q[wr_idx];
    wr_victim   = lru_oldest(lru_wr_base);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[wr_idx][w]) wr_victim = way_t'(w);
    end
    wr_sel    = wr_hit ? wr_way : wr_victim;
    wr_alloc  = !wr_hit && (btb_branch_taken || ALLOC_NOT_TAKEN);
    wr_en     = btb_write && !btb_flush && (wr_hit || wr_alloc);
    wr_tgt_en = btb_branch_taken || !wr_hit;
    lru_wr_d  = lru_touch(lru_wr_base, wr_sel);
  end

  assign wr_cur_ctr = ctr_q[wr_way][wr_idx];
  assign wr_ctr     = wr_hit ? ctr_upd : (btb_branch_taken ? CTR_MAX : CTR_MIN);

  btb_sat_counter #(
    .CTR_W(CTR_W)
  ) u_sat_counter (
    .taken    (btb_branch_taken),
    .current  (wr_cur_ctr),
    .next_ctr (ctr_upd)
  );

  always_comb begin
    hit_count_d = hit_count_q;
    if (lookup_touch && hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
  end

  assign btb_hit_count = hit_count_q;

  always_ff @(posedge btb_clk or posedge btb_reset) begin
    if (btb_reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        lru_q[s]   <= AGES_INIT;
      end
      hit_count_q <= '0;
    end else begin
      hit_count_q <= hit_count_d;
      if (btb_flush) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          lru_q[s]   <= AGES_INIT;
        end
      end else begin
        if (lookup_touch) lru_q[rd_idx] <= lru_rd_d;
        if (wr_en) begin
          lru_q[wr_idx]           <= lru_wr_d;
          valid_q[wr_idx][wr_sel] <= 1'b1;
        end
      end
    end
  end

  // Payload arrays carry no reset; an entry is only visible once its valid bit is set.
  always_ff @(posedge btb_clk) begin
    if (!btb_reset && wr_en) begin
      tag_q[wr_sel][wr_idx] <= wr_tag;
      ctr_q[wr_sel][wr_idx] <= wr_ctr;
      if (wr_tgt_en) tgt_q[wr_sel][wr_idx] <= btb_data;
    end
  end

endmodule

// File: tb/tb_assoc_branch_target_buffer.sv
// Self-checking bench for assoc_branch_target_buffer against a timestamp-based
// behavioural model of the buffer contents and recency order.
module tb_assoc_branch_target_buffer;

  localparam int ENTRIES  = 1024;
  localparam int WAYS     = 2;
  localparam int PC_W     = 32;
  localparam int CTR_W    = 2;
  localparam bit ALLOC    = 1'b1;
  localparam int SETS     = ENTRIES / WAYS;
  localparam int IDX_W    = 9;
  localparam int CTR_MAXV = (1 << CTR_W) - 1;
  localparam int CTR_MSB  = 1 << (CTR_W - 1);

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic [PC_W-1:0] pc_i = '0;
  logic            en_i = 1'b0;
  logic            wr_i = 1'b0;
  logic [PC_W-1:0] new_pc_i = '0;
  logic [PC_W-1:0] data_i = '0;
  logic            taken_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            btb_hit, btb_valid_prediction;
  logic [PC_W-1:0] btb_target;
  logic [31:0]     btb_hit_count;

  assoc_branch_target_buffer #(
    .ENTRIES(ENTRIES), .WAYS(WAYS), .PC_W(PC_W), .CTR_W(CTR_W), .ALLOC_NOT_TAKEN(ALLOC)
  ) dut (
    .btb_clk              (clk),
    .btb_reset            (rst_i),
    .btb_pc               (pc_i),
    .btb_lookup_en        (en_i),
    .btb_write            (wr_i),
    .btb_new_pc           (new_pc_i),
    .btb_data             (data_i),
    .btb_branch_taken     (taken_i),
    .btb_flush            (flush_i),
    .btb_hit              (btb_hit),
    .btb_valid_prediction (btb_valid_prediction),
    .btb_target           (btb_target),
    .btb_hit_count        (btb_hit_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each way remembers the time it was last touched; the victim is the oldest.
  bit              m_valid [SETS][WAYS];
  int              m_tag   [SETS][WAYS];
  logic [PC_W-1:0] m_tgt   [SETS][WAYS];
  int              m_ctr   [SETS][WAYS];
  longint          m_stamp [SETS][WAYS];
  longint          m_time  = 0;
  longint unsigned m_hits  = 0;

  function automatic int set_of(logic [PC_W-1:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic int tag_of(logic [PC_W-1:0] pc);
    return int'(pc >> (IDX_W + 2));
  endfunction

  function automatic int m_find(logic [PC_W-1:0] pc);
    int s;
    s = set_of(pc);
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) return w;
    return -1;
  endfunction

  function automatic bit exp_hit(logic [PC_W-1:0] pc);
    return m_find(pc) >= 0;
  endfunction

  function automatic bit exp_pred(logic [PC_W-1:0] pc);
    int w;
    w = m_find(pc);
    return (w >= 0) && (m_ctr[set_of(pc)][w] >= CTR_MSB);
  endfunction

  function automatic logic [PC_W-1:0] exp_target(logic [PC_W-1:0] pc);
    if (exp_pred(pc)) return m_tgt[set_of(pc)][m_find(pc)];
    return pc + 32'd4;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endfunction

  function automatic void m_update();
    int lw, ws, ww, v;
    lw = m_find(pc_i);
    if (en_i && lw >= 0 && m_hits < 64'hFFFF_FFFF) m_hits++;
    if (flush_i) begin
      m_clear();
      return;
    end
    if (en_i && lw >= 0) begin
      m_time++;
      m_stamp[set_of(pc_i)][lw] = m_time;
    end
    if (!wr_i) return;
    ws = set_of(new_pc_i);
    ww = m_find(new_pc_i);
    if (ww >= 0) begin
      if (taken_i) begin
        if (m_ctr[ws][ww] < CTR_MAXV) m_ctr[ws][ww]++;
        m_tgt[ws][ww] = data_i;
      end else if (m_ctr[ws][ww] > 0) begin
        m_ctr[ws][ww]--;
      end
      m_time++;
      m_stamp[ws][ww] = m_time;
    end else if (taken_i || ALLOC) begin
      v = -1;
      for (int w = 0; w < WAYS; w++) if (!m_valid[ws][w] && v < 0) v = w;
      if (v < 0) begin
        v = 0;
        for (int w = 1; w < WAYS; w++) if (m_stamp[ws][w] < m_stamp[ws][v]) v = w;
      end
      m_valid[ws][v] = 1'b1;
      m_tag[ws][v]   = tag_of(new_pc_i);
      m_tgt[ws][v]   = data_i;
      m_ctr[ws][v]   = taken_i ? CTR_MAXV : 0;
      m_time++;
      m_stamp[ws][v] = m_time;
    end
  endfunction

  task automatic idle();
    en_i = 1'b0; wr_i = 1'b0; flush_i = 1'b0; taken_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_i) begin
      m_clear();
      m_hits = 0;
    end else begin
      m_update();
    end
    @(negedge clk);
  endtask

  task automatic do_write(logic [PC_W-1:0] pc, logic [PC_W-1:0] data, logic taken);
    idle();
    wr_i = 1'b1; new_pc_i = pc; data_i = data; taken_i = taken;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    #1 rst_i = 1'b1;
    @(negedge clk);
    pc_i = 32'h100;
    #1;
    n_tests++; if (btb_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hit: got %b want 0", btb_hit); end
    n_tests++; if (btb_valid_prediction !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pred: got %b want 0", btb_valid_prediction); end
    n_tests++; if (btb_target !== 32'h104) begin n_fail++; $display("[TB] FAIL reset_target: got %h want 00000104", btb_target); end
    n_tests++; if (btb_hit_count !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d want 0", btb_hit_count); end
    m_clear();
    m_hits = 0;
    @(negedge clk);
    rst_i = 1'b0;
    en_i = 1'b1;
    tick();
    #1;
    n_tests++; if (btb_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_hit: got %b want 0", btb_hit); end
    n_tests++; if (btb_target !== 32'h104) begin n_fail++; $display("[TB] FAIL post_reset_target: got %h want 00000104", btb_target); end
    idle();
  endtask

  task automatic test_taken_write();
    do_write(32'h100, 32'h200, 1'b1);
    pc_i = 32'h100; en_i = 1'b1;
    #1;
    n_tests++; if (btb_hit !== 1'b1) begin n_fail++; $display("[TB] FAIL taken_hit: got %b want 1", btb_hit); end
    n_tests++; if (btb_valid_prediction !== 1'b1) begin n_fail++; $display("[TB] FAIL taken_pred: got %b want 1", btb_valid_prediction); end
    n_tests++; if (btb_target !== 32'h200) begin n_fail++; $display("[TB] FAIL taken_target: got %h want 00000200", btb_target); end
    tick();
    idle();
    n_tests++; if (btb_hit_count !== 32'd1) begin n_fail++; $display("[TB] FAIL taken_count: got %0d want 1", btb_hit_count); end
  endtask

  task automatic test_counter_decay();
    for (int i = 0; i < 3; i++) do_write(32'h100, 32'h0, 1'b0);
    pc_i = 32'h100;
    #1;
    n_tests++; if (btb_hit !== 1'b1) begin n_fail++; $display("[TB] FAIL decay_hit: got %b want 1", btb_hit); end
    n_tests++; if (btb_valid_prediction !== 1'b0) begin n_fail++; $display("[TB] FAIL decay_pred: got %b want 0", btb_valid_prediction); end
    n_tests++; if (btb_target !== 32'h104) begin n_fail++; $display("[TB] FAIL decay_target: got %h want 00000104", btb_target); end
    n_tests++; if (btb_target !== exp_target(32'h100)) begin n_fail++; $display("[TB] FAIL decay_model_target: got %h want %h", btb_target, exp_target(32'h100)); end
  endtask

  task automatic test_lru_evict();
    idle(); flush_i = 1'b1; tick(); idle();
    do_write(32'h100, 32'h2000, 1'b1);
    do_write(32'h900, 32'h3000, 1'b1);
    pc_i = 32'h100; en_i = 1'b1; tick(); idle();
    do_write(32'h1100, 32'h4000, 1'b1);
    pc_i = 32'h900; #1;
    n_tests++; if (btb_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL lru_evicted_900: got %b want 0", btb_hit); end
    pc_i = 32'h100; #1;
    n_tests++; if (btb_hit !== 1'b1) begin n_fail++; $display("[TB] FAIL lru_kept_100: got %b want 1", btb_hit); end
    n_tests++; if (btb_target !== 32'h2000) begin n_fail++; $display("[TB] FAIL lru_target_100: got %h want 00002000", btb_target); end
    pc_i = 32'h1100; #1;
    n_tests++; if (btb_hit !== 1'b1) begin n_fail++; $display("[TB] FAIL lru_new_1100: got %b want 1", btb_hit); end
    n_tests++; if (btb_target !== 32'h4000) begin n_fail++; $display("[TB] FAIL lru_target_1100: got %h want 00004000", btb_target); end
  endtask

  task automatic test_back_to_back();
    idle(); flush_i = 1'b1; tick(); idle();
    do_write(32'h100, 32'h2000, 1'b1);
    do_write(32'h900, 32'h3000, 1'b1);
    pc_i = 32'h100; en_i = 1'b1;
    wr_i = 1'b1; new_pc_i = 32'h1100; data_i = 32'h4000; taken_i = 1'b1;
    #1;
    n_tests++; if (btb_target !== 32'h2000) begin n_fail++; $display("[TB] FAIL b2b_prewrite_target: got %h want 00002000", btb_target); end
    tick(); idle();
    pc_i = 32'h900; #1;
    n_tests++; if (btb_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_evicted_900: got %b want 0", btb_hit); end
    pc_i = 32'h100; #1;
    n_tests++; if (btb_hit !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_kept_100: got %b want 1", btb_hit); end
    do_write(32'h1900, 32'h5000, 1'b1);
    pc_i = 32'h100; #1;
    n_tests++; if (btb_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_second_evicted_100: got %b want 0", btb_hit); end
    pc_i = 32'h1100; #1;
    n_tests++; if (btb_hit !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_mru_1100: got %b want 1", btb_hit); end
  endtask

  task automatic test_flush();
    logic [31:0] count_before;
    do_write(32'h300, 32'h7000, 1'b1);
    do_write(32'h500, 32'h7100, 1'b1);
    count_before = btb_hit_count;
    idle();
    flush_i = 1'b1; wr_i = 1'b1; new_pc_i = 32'h300; data_i = 32'h7200; taken_i = 1'b1;
    tick(); idle();
    pc_i = 32'h300; #1;
    n_tests++; if (btb_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_300: got %b want 0", btb_hit); end
    for (int i = 0; i < 4; i++) begin
      pc_i = (i == 0) ? 32'h500 : (i == 1) ? 32'h1100 : (i == 2) ? 32'h1900 : 32'h900;
      #1;
      n_tests++; if (btb_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_miss_%0d: got %b want 0 pc %h", i, btb_hit, pc_i); end
    end
    n_tests++; if (btb_hit_count !== count_before) begin n_fail++; $display("[TB] FAIL flush_count: got %0d want %0d", btb_hit_count, count_before); end
  endtask

  task automatic test_random();
    logic [PC_W-1:0] p;
    for (int c = 0; c < 400; c++) begin
      idle();
      p = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, 2)) << 2) | 32'($urandom_range(0, 3));
      pc_i = p;
      en_i = ($urandom_range(0, 3) != 0);
      wr_i = $urandom_range(0, 1);
      new_pc_i = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, 2)) << 2);
      data_i = $urandom & 32'hFFFF_FFFC;
      taken_i = $urandom_range(0, 1);
      flush_i = ($urandom_range(0, 49) == 0);
      #1;
      n_tests++; if (btb_hit !== exp_hit(p)) begin n_fail++; $display("[TB] FAIL rand_hit c%0d: got %b want %b pc %h", c, btb_hit, exp_hit(p), p); end
      n_tests++; if (btb_valid_prediction !== exp_pred(p)) begin n_fail++; $display("[TB] FAIL rand_pred c%0d: got %b want %b pc %h", c, btb_valid_prediction, exp_pred(p), p); end
      n_tests++; if (btb_target !== exp_target(p)) begin n_fail++; $display("[TB] FAIL rand_target c%0d: got %h want %h pc %h", c, btb_target, exp_target(p), p); end
      tick();
      n_tests++; if (btb_hit_count !== m_hits[31:0]) begin n_fail++; $display("[TB] FAIL rand_count c%0d: got %0d want %0d", c, btb_hit_count, m_hits[31:0]); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_write(32'h100, 32'h2000, 1'b1);
    do_write(32'h900, 32'h3000, 1'b1);
    pc_i = 32'h100; en_i = 1'b1; tick(); idle();
    pc_i = 32'h100; #1;
    n_tests++; if (btb_hit !== 1'b1) begin n_fail++; $display("[TB] FAIL arst_pre_hit: got %b want 1", btb_hit); end
    #1 rst_i = 1'b1;
    m_clear(); m_hits = 0;
    #1;
    n_tests++; if (btb_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_hit: got %b want 0", btb_hit); end
    n_tests++; if (btb_target !== 32'h104) begin n_fail++; $display("[TB] FAIL arst_target: got %h want 00000104", btb_target); end
    n_tests++; if (btb_hit_count !== 32'd0) begin n_fail++; $display("[TB] FAIL arst_count: got %0d want 0", btb_hit_count); end
    @(negedge clk);
    rst_i = 1'b0;
    wr_i = 1'b1; new_pc_i = 32'h4000; data_i = 32'h8000; taken_i = 1'b1;
    #2 rst_i = 1'b1;
    @(posedge clk);
    #2 rst_i = 1'b0;
    idle();
    @(negedge clk);
    pc_i = 32'h4000; #1;
    n_tests++; if (btb_hit !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_discard_write: got %b want 0", btb_hit); end
  endtask

  initial begin
    test_reset();
    test_taken_write();
    test_counter_decay();
    test_lru_evict();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
